// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: active-low hex
// glyph table (dp bit held off) and the idle values of the segment/anode buses.
package sseg_pkg;

  // Entry n is the glyph for nibble n, {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [15:0][7:0] HEX_SSEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    return HEX_SSEG[nib];
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bundle: digit/dp/brightness inputs from the scroller and the
// multiplexed pin outputs.
interface sseg_scan_ctrl_if;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bright;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  modport master (
    output digits, dp_in, lz_en, bright,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  digits, dp_in, lz_en, bright,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl_lz_blank_mask.sv
// Leading-zero mask: bit k set when digit k and every digit above it are zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module lz_blank_mask (
    input  logic [31:0] digits_i,
    output logic [7:0]  mask_o
);
    always_comb begin
        mask_o    = '0;
        mask_o[7] = (digits_i[31:28] == 4'h0);
        for (int k = 6; k >= 1; k--) begin
            mask_o[k] = mask_o[k+1] && (digits_i[4*k +: 4] == 4'h0);
        end
    end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit time-multiplexed seven-segment driver with frame-synchronous
// shadow registers, leading-zero blanking and 16-step PWM brightness.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int SCAN_BITS = 17
) (
    input  logic             clk,
    input  logic             reset,
    sseg_scan_ctrl_if.slave  dsp
);

    logic [SCAN_BITS-1:0] pre_q, pre_d;
    logic [2:0]           idx_q, idx_d;
    logic [31:0]          sh_digits_q, sh_digits_d;
    logic [7:0]           sh_dp_q, sh_dp_d;
    logic                 sh_lz_q, sh_lz_d;
    logic [3:0]           sh_bright_q, sh_bright_d;
    logic [7:0]           an_q, an_d;
    logic [7:0]           sseg_q, sseg_d;
    logic                 tick_q, tick_d;

    logic       wrap, frame_end, blank, pwm_on;
    logic [3:0] phase, nib;
    logic [7:0] glyph, lz_mask;

    lz_blank_mask u_lz (
        .digits_i (sh_digits_q),
        .mask_o   (lz_mask)
    );

    assign wrap      = &pre_q;
    assign frame_end = wrap && (idx_q == 3'd7);
    assign phase     = pre_q[SCAN_BITS-1 -: 4];
    assign nib       = sh_digits_q[{idx_q, 2'b00} +: 4];
    assign glyph     = hex_decode(nib);
    assign blank     = sh_lz_q && lz_mask[idx_q];
    assign pwm_on    = (phase <= sh_bright_q);

    always_comb begin
        pre_d       = pre_q + 1'b1;
        idx_d       = idx_q;
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_lz_d     = sh_lz_q;
        sh_bright_d = sh_bright_q;
        tick_d      = frame_end;
        if (wrap) idx_d = idx_q + 3'd1;
        // Latch the next frame's content only at the boundary so a scroll never tears.
        if (frame_end) begin
            sh_digits_d = dsp.digits;
            sh_dp_d     = dsp.dp_in;
            sh_lz_d     = dsp.lz_en;
            sh_bright_d = dsp.bright;
        end
        an_d   = pwm_on ? ~(8'b1 << idx_q) : AN_OFF;
        sseg_d = {~sh_dp_q[idx_q], blank ? 7'h7F : glyph[6:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            idx_q       <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_lz_q     <= 1'b0;
            sh_bright_q <= '0;
            an_q        <= AN_OFF;
            sseg_q      <= SSEG_BLANK;
            tick_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_lz_q     <= sh_lz_d;
            sh_bright_q <= sh_bright_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            tick_q      <= tick_d;
        end
    end

    assign dsp.an         = an_q;
    assign dsp.sseg       = sseg_q;
    assign dsp.frame_tick = tick_q;

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Downstream display stage for the eight-digit scroller. It takes the eight hex nibbles plus per-digit decimal points and time-multiplexes them onto the shared active-low segment bus and anode lines. It adds three things: a frame-synchronous shadow register so scrolling updates never tear mid-frame, optional leading-zero blanking, and 4-bit PWM brightness per digit slot.

Parameters:
SCAN_BITS, 17, prescaler width; one digit slot = 2^SCAN_BITS clocks (763 Hz/digit, 95 Hz frame at 100 MHz); legal range >= 5

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous reset, active-high
digits  in  32  hex digits; digits[4k+3:4k] = digit k, k=0 rightmost
dp_in  in  8  decimal point per digit, 1 = lit
lz_en  in  1  1 = blank leading zeros (digit 0 never blanked)
bright  in  4  brightness; anode on for phases 0..bright of 16
an  out  8  anodes, active-low, one-hot-low or all ones
sseg  out  8  {dp,g,f,e,d,c,b,a}, active-low
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: an=8'hFF, sseg=8'hFF, frame_tick=0, prescaler=0, digit index=0, shadow digits=0, shadow dp=0, shadow lz/bright=0.
- Prescaler increments every cycle and wraps at 2^SCAN_BITS-1. On wrap, index increments 0..7 and wraps 7->0.
- Frame boundary = the cycle where prescaler is all ones and index=7. In that cycle:
  - shadow registers capture digits, dp_in, lz_en and bright;
  - frame_tick is registered, so it is high the following cycle, the first cycle of slot 0.
- Inputs changing mid-frame have no effect until the next frame boundary.
- phase = prescaler[SCAN_BITS-1 -: 4]; the slot's anode is enabled when phase <= shadow bright. bright=15 gives full duty; bright=0 gives 1/16.
- Leading-zero blanking: when shadow lz is set, digit k is blanked if k>0, digit k is zero, and every digit above k is zero. Blanking forces segments a-g off; dp still follows the dp shadow.
- Segment value: hex decode of the shadow digit at index, dp bit = ~dp_shadow[index]; a blanked digit drives 7'h7F on g..a.
- an = ~(8'b1 << index) when the PWM enable is true, else 8'hFF. sseg is driven regardless of anode state.
- an and sseg are registered: one-cycle latency from index/phase/shadow to pins.
- Reset mid-slot: on the next edge, outputs go to reset values and scanning restarts at index 0, phase 0. The first frame after reset shows shadow zeros with bright=0, i.e. 1/16 duty.
- No other state machine; index and prescaler form the scan state.

Decomposition:
- Package sseg_pkg holds:
  - the constant 16-entry active-low hex decode table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E, listed with dp=1;
  - SSEG_BLANK=8'hFF and AN_OFF=8'hFF.
- One sub-module, lz_blank_mask: combinational, maps 32-bit digits to an 8-bit blank mask.

Test Plan:
(All with SCAN_BITS=5, slot=32 cycles, each phase 2 cycles.)
1. Reset held 3 cycles -> an=FF, sseg=FF, frame_tick=0. After release, slot 0 shows an=FE, sseg=C0 for 2 cycles (phases 0), then an=FF for the rest of the slot (shadow bright=0).
2. digits=32'h89ABCDEF, bright=15, dp=0, lz_en=0, applied before the first frame boundary -> frame_tick pulses after cycle 255. Next frame:
   - slot k drives an=~(1<<k) for all 32 cycles;
   - sseg: slot 0=8E, 1=86, 2=A1, 3=C6, 4=83, 5=88, 6=90, 7=80.
3. bright=3 latched -> in every slot an is active for cycles 0-7 (with 1-cycle output latency) and FF for cycles 8-31.
4. digits change 32'h11111111 -> 32'h22222222 at cycle 100 of a frame -> sseg stays F9 for the remainder of that frame. A4 appears from slot 0 of the next frame, coincident with frame_tick.
5. lz_en=1, digits=32'h00000400, dp_in=8'h10 ->
   - slots 7,6,5,3: sseg=FF;
   - slot 4: sseg=7F;
   - slot 2: 99; slots 1,0: C0.
6. Reset asserted at cycle 150 of a frame (index 4) -> next edge an=FF, sseg=FF, frame_tick=0. After release, scan restarts at slot 0 and the shadow is cleared: digits show 0, dp off, bright=0.
